// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit and the ripple ALU it drives.
package mdu_pkg;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  localparam logic [2:0] ALUOP_AND = 3'b000;
  localparam logic [2:0] ALUOP_OR  = 3'b001;
  localparam logic [2:0] ALUOP_ADD = 3'b010;
  localparam logic [2:0] ALUOP_SUB = 3'b110;
  localparam logic [2:0] ALUOP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// Pipeline-controller side of the multiply/divide unit: start/busy/done plus operands and HI/LO.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/alu32.sv
// Ripple-carry ALU shared by the execute stage; carry-in comes from the invert-b bit.
module alu32
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_aluop,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout
);

  logic [WIDTH-1:0] w_bb;
  logic [WIDTH-1:0] w_sum;
  logic             w_c;
  logic             w_cmsb;

  always_comb begin
    w_bb   = i_b ^ {WIDTH{i_aluop[2]}};
    w_c    = i_aluop[2];
    w_cmsb = 1'b0;
    w_sum  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) w_cmsb = w_c;
      w_sum[i] = i_a[i] ^ w_bb[i] ^ w_c;
      w_c      = (i_a[i] & w_bb[i]) | (w_c & (i_a[i] ^ w_bb[i]));
    end
    o_cout = w_c;

    case (i_aluop)
      ALUOP_AND: o_result = i_a & w_bb;
      ALUOP_OR:  o_result = i_a | w_bb;
      ALUOP_ADD,
      ALUOP_SUB: o_result = w_sum;
      // signed less-than: sign of the difference corrected by overflow
      ALUOP_SLT: o_result = WIDTH'(w_sum[WIDTH-1] ^ (w_cmsb ^ w_c));
      default:   o_result = w_sum;
    endcase
  end

endmodule

// File: rtl/mult_div_unit_step.sv
// One shift-add (MULTU) or restoring-subtract (DIVU) iteration of the {hi,lo} pair.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_cout,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH-1:0] w_rem;
  logic             w_t;

  assign w_rem   = {i_hi[WIDTH-2:0], i_lo[WIDTH-1]};
  assign w_t     = i_hi[WIDTH-1];
  assign o_alu_a = (i_op == OP_DIVU) ? w_rem : i_hi;

  always_comb begin
    o_hi = i_hi;
    o_lo = i_lo;
    if (i_op == OP_DIVU) begin
      // a bit shifted out of hi means the true remainder already exceeds the divisor
      if (w_t | i_alu_cout) begin
        o_hi = i_alu_result;
        o_lo = {i_lo[WIDTH-2:0], 1'b1};
      end else begin
        o_hi = w_rem;
        o_lo = {i_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (i_lo[0]) begin
        {o_hi, o_lo} = {i_alu_cout, i_alu_result, i_lo[WIDTH-1:1]};
      end else begin
        {o_hi, o_lo} = {1'b0, i_hi, i_lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULTU/DIVU unit; every iteration borrows the shared ripple ALU for its add/subtract.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_if.slave   bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_aluop,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;
  logic             r_op;
  logic             r_dbz;
  logic [CW-1:0]    r_count;

  logic             w_accept;
  logic             w_div0;
  logic             w_last;
  logic [WIDTH-1:0] w_step_alu_a;
  logic [WIDTH-1:0] w_next_hi;
  logic [WIDTH-1:0] w_next_lo;

  assign w_accept = (r_state == ST_IDLE) && bus.start;
  assign w_div0   = (bus.op == OP_DIVU) && (bus.b == '0);
  assign w_last   = (r_count == CW'(WIDTH - 1));

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .i_op         (r_op),
    .i_hi         (r_hi),
    .i_lo         (r_lo),
    .i_alu_result (alu_result),
    .i_alu_cout   (alu_cout),
    .o_alu_a      (w_step_alu_a),
    .o_hi         (w_next_hi),
    .o_lo         (w_next_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_aluop = ALUOP_ADD;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_next = w_div0 ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        bus.busy  = 1'b1;
        alu_a     = w_step_alu_a;
        alu_b     = r_opnd;
        alu_aluop = (r_op == OP_DIVU) ? ALUOP_SUB : ALUOP_ADD;
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        bus.done = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_opnd  <= '0;
      r_op    <= OP_MULTU;
      r_dbz   <= 1'b0;
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= '0;
      r_op    <= bus.op;
      r_opnd  <= bus.b;
      if (w_div0) begin
        r_hi  <= bus.a;
        r_lo  <= '1;
        r_dbz <= 1'b1;
      end else begin
        r_hi  <= '0;
        r_lo  <= bus.a;
        r_dbz <= 1'b0;
      end
    end else if (r_state == ST_RUN) begin
      r_hi    <= w_next_hi;
      r_lo    <= w_next_lo;
      r_count <= r_count + 1'b1;
    end
  end

  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle unsigned multiply/divide unit for the MIPS datapath, producing HI/LO for MULTU and DIVU. It uses no adder of its own. Each iteration drives the shared 32-bit ripple ALU through its operand/aluop interface and consumes the ALU's result and carry-out. It sits beside the main ALU in the execute stage, and the pipeline controller uses it through a start/busy/done handshake.

## Interface
Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; one clock; no other reset
- start  in  1  request; sampled only in IDLE
- op  in  1  0 = MULTU, 1 = DIVU
- a  in  WIDTH  multiplicand / dividend
- b  in  WIDTH  multiplier / divisor
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse in DONE
- div_by_zero  out  1  registered; set by DIVU with b==0, cleared by next accepted start
- hi  out  WIDTH  product[63:32] / remainder
- lo  out  WIDTH  product[31:0] / quotient
- alu_a  out  WIDTH  ALU operand A
- alu_b  out  WIDTH  ALU operand B
- alu_aluop  out  3  ALU control: [2] invert-b/carry-in, [1:0] 00 AND, 01 OR, 10 ADD/SUB, 11 SLT
- alu_result  in  WIDTH  ALU sum/difference, combinational from alu_*
- alu_cout  in  1  ALU MSB carry-out

## Operation
- States: IDLE, RUN, DONE. In IDLE, start=1 moves to RUN. The exception is DIVU with b==0, which goes to DONE. RUN moves to DONE after iteration WIDTH-1. DONE always moves to IDLE after one cycle.
- Start accept (IDLE, start=1) loads:
  - MULTU: hi←0, lo←a, operand register←b.
  - DIVU: hi←0, lo←a, operand register←b.
  - Both: count←0, div_by_zero←0.
- DIVU with b==0 loads differently: hi←a, lo←all-ones, div_by_zero←1, and no iterations run.
- MULTU iteration (alu_aluop=010, alu_a=hi, alu_b=operand register):
  - If lo[0]=1: {hi,lo}←{alu_cout, alu_result, lo[WIDTH-1:1]}.
  - Otherwise: {hi,lo}←{0, hi, lo[WIDTH-1:1]}.
- DIVU iteration (restoring; alu_aluop=110):
  - Shifted remainder r'={hi[WIDTH-2:0], lo[WIDTH-1]}, with out-bit t=hi[WIDTH-1].
  - alu_a=r', alu_b=operand register.
  - If t|alu_cout: hi←alu_result, lo←{lo[WIDTH-2:0],1}.
  - Otherwise: hi←r', lo←{lo[WIDTH-2:0],0}.
- Outside RUN: alu_a=0, alu_b=0, alu_aluop=010.
- hi, lo and div_by_zero hold after DONE until the next accepted start.
- start in RUN or DONE is ignored; there is no queueing.
- a, b and op are sampled only at accept; changes during RUN have no effect.

## Timing
- Reset values: state IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, count=0, alu_* outputs=0 except alu_aluop=010.
- Reset asserted mid-RUN aborts immediately. Deasserting reset returns to IDLE with no done pulse.
- Normal operation, start accepted at edge 0:
  - busy=1 after edges 0..WIDTH-1.
  - Iterations occur at edges 1..WIDTH.
  - The state enters DONE at edge WIDTH.
  - done=1 for exactly one cycle after edge WIDTH; busy=0 in that cycle, and hi/lo are final.
- Divide by zero: done=1 in the cycle after edge 0; busy never asserts.
- Next start accepted at the earliest one cycle after done, i.e. the IDLE cycle.
- ALU path: alu_* outputs are registered-state-derived and alu_result is combinational, so the path per cycle is register → ALU ripple → register.

## Structure
- Shared package mdu_pkg holds:
  - the op encoding (OP_MULTU=0, OP_DIVU=1);
  - the ALU opcodes ALUOP_AND=000, ALUOP_OR=001, ALUOP_ADD=010, ALUOP_SUB=110, ALUOP_SLT=111, which are also used by the ALU control decoder;
  - the state enum.
- One sub-module, mdu_step: combinational next-{hi,lo} computation from op, hi, lo, alu_result and alu_cout.
- The FSM, counter and registers live in the top level.
- The bench instantiates the real 32-bit ALU on the alu_* ports.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done 32 cycles after accept; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 32 cycles.
- DIVU a=100, b=7 → hi=2, lo=14. DIVU a=0x80000000, b=3 → lo=0x2AAAAAAA, hi=2 (exercises the t=1 path).
- DIVU a=0x1234, b=0 → done the cycle after accept; hi=0x1234, lo=0xFFFFFFFF, div_by_zero=1. Next MULTU 3×5 → div_by_zero=0, lo=15, hi=0.
- start held high throughout MULTU 7×6 → only one operation runs; done pulses once with lo=42, then a second accept occurs in the following IDLE cycle.
- reset asserted at iteration 10 of DIVU → outputs go to reset values asynchronously; no done pulse; a fresh DIVU 9/2 then gives lo=4, hi=1.
- MULTU 0x12345678 × 0 and 0 × 0xFFFFFFFF → hi=lo=0. alu_aluop=010 throughout MULTU and 110 throughout the DIVU RUN states.
